// File: rtl/sec_ascii_formatter_if.sv
// sec_ascii_formatter_if
//   Byte stream from the seconds formatter to the UART transmitter.
//   A byte transfers in any cycle where uart_tx_enable and uart_tx_ready are both high.
//   Signals:
//     uart_tx_data    8  ASCII byte (formatter -> UART)
//     uart_tx_enable  1  byte valid (formatter -> UART)
//     uart_tx_ready   1  UART can take a byte this cycle (UART -> formatter)
//   Modports: master = formatter side, slave = UART side.
interface sec_ascii_formatter_if;
  logic [7:0] uart_tx_data;
  logic       uart_tx_enable;
  logic       uart_tx_ready;

  modport master (output uart_tx_data, output uart_tx_enable, input uart_tx_ready);
  modport slave  (input uart_tx_data, input uart_tx_enable, output uart_tx_ready);
endinterface

// File: rtl/sec_ascii_formatter.sv
// sec_ascii_formatter
//   On each rising edge of pps, latches the seconds count, converts it to BCD with a
//   bit-serial double-dabble (one bit per cycle), then streams "DDDDD" plus CR LF (or LF
//   only when EOL_CRLF=0) to the UART, one byte per valid/ready transfer.
//   Optional build macro SEC_ZERO_SUPPRESS_EN: when defined, leading zero digits are
//   skipped (at least one digit is always sent).
//   Ports:
//     clk_50m   in   system clock
//     reset_n   in   asynchronous active-low reset
//     second    in   seconds count from the timer
//     pps       in   pulse-per-second level; rising edge starts a message
//     tx        if   master side of the UART byte stream (data/enable out, ready in)
//     busy      out  high from capture until the last byte transfers
//     overrun   out  one-cycle pulse when a pps edge is dropped
//
//   state | meaning
//   IDLE  | waiting for a pps rising edge
//   CONV  | double-dabble conversion, SEC_W cycles
//   SEND  | presenting digit/terminator bytes to the UART
module sec_ascii_formatter #(
  parameter int SEC_W    = 16,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic                  clk_50m,
  input  logic                  reset_n,
  input  logic [SEC_W-1:0]      second,
  input  logic                  pps,
  sec_ascii_formatter_if.master tx,
  output logic                  busy,
  output logic                  overrun
);
  // 5 BCD digits sit above the binary part of the shift register.
  localparam int SR_W  = SEC_W + 20;
  localparam int CNT_W = $clog2(SEC_W);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  state_t            state, state_nxt;
  logic              pps_q;
  logic              pps_evt;
  logic [SR_W-1:0]   sr, sr_nxt, sr_step;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [2:0]        idx, idx_nxt, start_idx, last_idx;
  logic [3:0]        digit;
  logic [7:0]        tx_byte;

  assign pps_evt  = pps & ~pps_q;
  assign busy     = (state != IDLE);
  assign last_idx = EOL_CRLF ? 3'd6 : 3'd5;

  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      if (v[SEC_W+4*i +: 4] >= 4'd5)
        t[SEC_W+4*i +: 4] = v[SEC_W+4*i +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  assign sr_step = dabble(sr);

  // Byte index 0..4 are digits MSD first, 5..6 the terminator. The first index is
  // chosen from the final dabble result so no idle cycle is spent skipping zeros.
`ifdef SEC_ZERO_SUPPRESS_EN
  logic seen_nz;
  always_comb begin
    start_idx = 3'd0;
    seen_nz   = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (!seen_nz && sr_step[SEC_W+4*i +: 4] == 4'd0)
        start_idx = start_idx + 3'd1;
      else
        seen_nz = 1'b1;
    end
  end
`else
  assign start_idx = 3'd0;
`endif

  always_comb begin
    case (idx)
      3'd0:    digit = sr[SEC_W+16 +: 4];
      3'd1:    digit = sr[SEC_W+12 +: 4];
      3'd2:    digit = sr[SEC_W+8  +: 4];
      3'd3:    digit = sr[SEC_W+4  +: 4];
      default: digit = sr[SEC_W    +: 4];
    endcase
  end

  always_comb begin
    if (idx <= 3'd4)
      tx_byte = 8'h30 + {4'h0, digit};
    else if (idx == 3'd5 && EOL_CRLF)
      tx_byte = 8'h0D;
    else
      tx_byte = 8'h0A;
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pps_q   <= 1'b0;
      sr      <= '0;
      cnt     <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      pps_q   <= pps;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      overrun <= pps_evt & busy;
    end
  end

  always_comb begin
    state_nxt         = state;
    sr_nxt            = sr;
    cnt_nxt           = cnt;
    idx_nxt           = idx;
    tx.uart_tx_enable = 1'b0;
    tx.uart_tx_data   = 8'h00;
    case (state)
      IDLE: begin
        if (pps_evt) begin
          sr_nxt    = {20'd0, second};
          cnt_nxt   = CNT_W'(SEC_W - 1);
          state_nxt = CONV;
        end
      end
      CONV: begin
        sr_nxt = sr_step;
        if (cnt == '0) begin
          state_nxt = SEND;
          idx_nxt   = start_idx;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      SEND: begin
        tx.uart_tx_enable = 1'b1;
        tx.uart_tx_data   = tx_byte;
        if (tx.uart_tx_ready) begin
          if (idx == last_idx)
            state_nxt = IDLE;
          else
            idx_nxt = idx + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sec_ascii_formatter.sv
// tb_sec_ascii_formatter
//   Drives two formatters (CR LF and LF-only terminators) from the same pps/second/ready
//   stimulus and compares every transferred byte against strings built from the decimal
//   value of the latched seconds count.
module tb_sec_ascii_formatter;
  logic        clk_50m = 1'b0;
  logic        reset_n;
  logic [15:0] second;
  logic        pps;
  logic        busy, overrun, busy_lf, overrun_lf;

  sec_ascii_formatter_if tx();
  sec_ascii_formatter_if tx_lf();
  assign tx_lf.uart_tx_ready = tx.uart_tx_ready;

  sec_ascii_formatter dut (
    .clk_50m (clk_50m),
    .reset_n (reset_n),
    .second  (second),
    .pps     (pps),
    .tx      (tx),
    .busy    (busy),
    .overrun (overrun)
  );

  sec_ascii_formatter #(.EOL_CRLF(1'b0)) dut_lf (
    .clk_50m (clk_50m),
    .reset_n (reset_n),
    .second  (second),
    .pps     (pps),
    .tx      (tx_lf),
    .busy    (busy_lf),
    .overrun (overrun_lf)
  );

  always #10 clk_50m = ~clk_50m;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_lf_q[$];
  int ovr_cnt    = 0;
  int ovr_lf_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", tag, act, exp);
  endtask

  // Reference: decimal digits by plain arithmetic, then the terminator.
  task automatic push_exp(input int v);
    int d[5];
    int s;
    d[0] = (v / 10000) % 10;
    d[1] = (v / 1000) % 10;
    d[2] = (v / 100) % 10;
    d[3] = (v / 10) % 10;
    d[4] = v % 10;
    s = 0;
`ifdef SEC_ZERO_SUPPRESS_EN
    while (s < 4 && d[s] == 0) s++;
`endif
    for (int i = s; i < 5; i++) begin
      exp_q.push_back(8'(32'h30 + d[i]));
      exp_lf_q.push_back(8'(32'h30 + d[i]));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_lf_q.push_back(8'h0A);
  endtask

  // Byte-stream monitors: order/content, hold-under-backpressure, overrun pulse width.
  logic       en_p, rdy_p, ovr_p, en_lp, rdy_lp, ovr_lp;
  logic [7:0] dat_p, dat_lp;

  always @(negedge clk_50m) begin
    if (!reset_n) begin
      en_p = 1'b0; rdy_p = 1'b0; ovr_p = 1'b0; dat_p = 8'h00;
    end else begin
      if (en_p && !rdy_p) begin
        chk("hold_en", tx.uart_tx_enable, 1);
        chk("hold_data", tx.uart_tx_data, dat_p);
      end
      if (tx.uart_tx_enable && tx.uart_tx_ready) begin
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("byte", tx.uart_tx_data, exp_q.pop_front());
      end
      if (overrun) begin
        chk("ovr_width", ovr_p, 0);
        ovr_cnt++;
      end
      en_p = tx.uart_tx_enable; rdy_p = tx.uart_tx_ready;
      ovr_p = overrun; dat_p = tx.uart_tx_data;
    end
  end

  always @(negedge clk_50m) begin
    if (!reset_n) begin
      en_lp = 1'b0; rdy_lp = 1'b0; ovr_lp = 1'b0; dat_lp = 8'h00;
    end else begin
      if (en_lp && !rdy_lp) begin
        chk("hold_en_lf", tx_lf.uart_tx_enable, 1);
        chk("hold_data_lf", tx_lf.uart_tx_data, dat_lp);
      end
      if (tx_lf.uart_tx_enable && tx_lf.uart_tx_ready) begin
        chk("byte_expected_lf", exp_lf_q.size() != 0, 1);
        if (exp_lf_q.size() != 0) chk("byte_lf", tx_lf.uart_tx_data, exp_lf_q.pop_front());
      end
      if (overrun_lf) begin
        chk("ovr_width_lf", ovr_lp, 0);
        ovr_lf_cnt++;
      end
      en_lp = tx_lf.uart_tx_enable; rdy_lp = tx_lf.uart_tx_ready;
      ovr_lp = overrun_lf; dat_lp = tx_lf.uart_tx_data;
    end
  end

  // mode: 0 ready=1, 1 random ready, 2 ready low 10 cycles at the 3rd byte.
  // e1/e2: cycle of an extra pps edge (0 = none). hold: pps high length (0 = 2 cycles).
  // rst_at: cycle at which reset is asserted (0 = none).
  task automatic run_msg(input int v, input int mode, input int e1, input int e2,
                         input int hold, input int rst_at);
    int k, lat, xfers, bp_left, min_k, o0, o1, exp_ovr;
    bit bp_done;
    o0 = ovr_cnt; o1 = ovr_lf_cnt;
    exp_ovr = (e1 > 0 ? 1 : 0) + (e2 > 0 ? 1 : 0);
    push_exp(v);
    lat = -1; xfers = 0; bp_left = 0; bp_done = 1'b0;
    min_k = 3;
    if (hold + 1 > min_k) min_k = hold + 1;
    if (e1 + 3 > min_k) min_k = e1 + 3;
    if (e2 + 3 > min_k) min_k = e2 + 3;
    @(posedge clk_50m); #1;
    second = 16'(v);
    pps    = 1'b1;
    chk("busy_c0", busy, 0);
    for (k = 0; k < 400; k++) begin
      if (k > 0) begin
        @(posedge clk_50m); #1;
      end
      if (k == 1) chk("busy_c1", busy, 1);
      if (k >= 1) second = 16'($urandom);
      if (lat < 0 && tx.uart_tx_enable) lat = k;
      if (hold == 0 && k == 2) pps = 1'b0;
      if (hold > 0 && k == hold) pps = 1'b0;
      if (e1 > 0 && k == e1) pps = 1'b1;
      if (e1 > 0 && k == e1 + 2) pps = 1'b0;
      if (e2 > 0 && k == e2) pps = 1'b1;
      if (e2 > 0 && k == e2 + 2) pps = 1'b0;
      if (rst_at > 0 && k == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_enable", tx.uart_tx_enable, 0);
        chk("rst_data", tx.uart_tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_enable_lf", tx_lf.uart_tx_enable, 0);
        chk("rst_busy_lf", busy_lf, 0);
        exp_q.delete();
        exp_lf_q.delete();
        pps = 1'b0;
        @(posedge clk_50m); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_50m);
        return;
      end
      case (mode)
        0: tx.uart_tx_ready = 1'b1;
        1: tx.uart_tx_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (xfers == 2 && !bp_done && tx.uart_tx_enable) begin
            bp_left = 10;
            bp_done = 1'b1;
          end
          tx.uart_tx_ready = (bp_left == 0);
          if (bp_left > 0) bp_left--;
        end
      endcase
      if (tx.uart_tx_enable && tx.uart_tx_ready) xfers++;
      if (k >= min_k && !busy && !busy_lf) break;
    end
    chk("timeout", k < 400, 1);
    chk("latency", lat, 17);
    chk("drain", exp_q.size(), 0);
    chk("drain_lf", exp_lf_q.size(), 0);
    chk("overrun", ovr_cnt - o0, exp_ovr);
    chk("overrun_lf", ovr_lf_cnt - o1, exp_ovr);
    tx.uart_tx_ready = 1'b1;
  endtask

  initial begin
    int v, r, e;
    reset_n = 1'b0;
    pps = 1'b0;
    second = 16'd0;
    tx.uart_tx_ready = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1;
    chk("reset_enable", tx.uart_tx_enable, 0);
    chk("reset_data", tx.uart_tx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    @(posedge clk_50m);

    run_msg(1234, 0, 0, 0, 0, 0);
    run_msg(65535, 0, 0, 0, 0, 0);
    run_msg(0, 0, 0, 0, 0, 0);
    run_msg(1234, 2, 0, 0, 0, 0);
    run_msg(54321, 0, 10, 20, 0, 0);
    run_msg(40000, 0, 0, 0, 0, 19);
    run_msg(7, 0, 0, 0, 0, 0);
    run_msg(5, 0, 0, 0, 100, 0);
    run_msg(0, 1, 0, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0) v = int'($urandom_range(0, 9));
      else if (r == 1) v = int'($urandom_range(0, 999));
      else v = int'($urandom_range(0, 65535));
      e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 15)) : 0;
      run_msg(v, 1, e, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
